// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
//
// Purpose
//   Sequencer that sits between an instruction source and an external ALU.
//   It owns a four-entry, 8-bit register file (r0-r3). Each instruction is
//   accepted in IDLE. Its operands are read from the register file, or taken
//   from an 8-bit immediate, and presented to the ALU for one cycle (SLOW=0)
//   or two cycles (SLOW=1). The ALU result and flags are then captured.
//   In the following WB cycle the block pulses o_done. The result and flags
//   are committed on the edge that leaves WB.
//
//   State path:  SLOW=0  IDLE -> EXEC -> WB -> IDLE
//                SLOW=1  IDLE -> EXEC -> WAIT -> WB -> IDLE
//
//   Instruction format (16 bits):
//     [15:13] func   ALU function (3'b111 = NOP: no register or flag write)
//     [12:11] rd     destination register
//     [10:9]  rs1    first source register
//     [8]     imm_sel  1: second operand = imm8, 0: second operand = r[rs2]
//     [7:0]   imm8 (imm_sel=1) / rs2 in [1:0] (imm_sel=0)
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_instr_valid    qualifies i_instr
//   o_instr_ready    high only in IDLE; acceptance = valid & ready at an edge
//   i_instr          instruction word (format above)
//   o_alu_s1/_s2     ALU operands, held outside EXEC/WAIT
//   o_alu_en         ALU enable, high in EXEC and WAIT
//   o_alu_func       ALU function code, held outside EXEC/WAIT
//   i_alu_result     ALU result
//   i_alu_zero/negative/overflow   ALU flags
//   o_done           one-cycle completion pulse (WB)
//   o_flags          committed flags {overflow, negative, zero}
//   i_dbg_addr       debug read address
//   o_dbg_data       combinational read of r[i_dbg_addr]
// -----------------------------------------------------------------------------
module alu_ctrl #(
    parameter logic SLOW = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [15:0] i_instr,

    output logic [7:0]  o_alu_s1,
    output logic [7:0]  o_alu_s2,
    output logic        o_alu_en,
    output logic [2:0]  o_alu_func,
    input  logic [7:0]  i_alu_result,
    input  logic        i_alu_zero,
    input  logic        i_alu_negative,
    input  logic        i_alu_overflow,

    output logic        o_done,
    output logic [2:0]  o_flags,

    input  logic [1:0]  i_dbg_addr,
    output logic [7:0]  o_dbg_data
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] FUNC_NOP = 3'b111;

    // -------------------------------------------------------------------------
    // Instruction field decode
    // -------------------------------------------------------------------------
    logic [2:0] instr_func;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic       instr_imm_sel;
    logic [7:0] instr_imm8;
    logic [1:0] instr_rs2;

    assign instr_func    = i_instr[15:13];
    assign instr_rd      = i_instr[12:11];
    assign instr_rs1     = i_instr[10:9];
    assign instr_imm_sel = i_instr[8];
    assign instr_imm8    = i_instr[7:0];
    assign instr_rs2     = i_instr[1:0];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0] state_q,  state_d;

    // Latched instruction / ALU interface
    logic [7:0] s1_q,     s1_d;
    logic [7:0] s2_q,     s2_d;
    logic [2:0] func_q,   func_d;
    logic [1:0] rd_q,     rd_d;

    // ALU result holding registers, filled on the edge leaving EXEC/WAIT
    logic [7:0] res_q,    res_d;
    logic [2:0] cflags_q, cflags_d;   // {overflow, negative, zero}

    // Committed architectural state
    logic [7:0] rf_q [4];
    logic [7:0] rf_d [4];
    logic [2:0] flags_q,  flags_d;

    // Registered handshake/status outputs, derived from the next state so
    // they are glitch-free and all read zero while reset is held.
    logic       ready_q,  ready_d;
    logic       en_q,     en_d;
    logic       done_q,   done_d;

    logic       accept;

    // ready_q is only ever set when the machine is in IDLE, so this alone
    // identifies the acceptance edge; valid in other states is ignored.
    assign accept = i_instr_valid & ready_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        func_d   = func_q;
        rd_d     = rd_q;
        res_d    = res_q;
        cflags_d = cflags_q;
        rf_d     = rf_q;
        flags_d  = flags_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Operands are read from the current register file. Any
                    // earlier instruction has already committed in WB, so no
                    // forwarding path is needed, even for rs == rd.
                    s1_d    = rf_q[instr_rs1];
                    s2_d    = instr_imm_sel ? instr_imm8 : rf_q[instr_rs2];
                    func_d  = instr_func;
                    rd_d    = instr_rd;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (SLOW) begin
                    // Give the ALU a second cycle before sampling it.
                    state_d = S_WAIT;
                end else begin
                    res_d    = i_alu_result;
                    cflags_d = {i_alu_overflow, i_alu_negative, i_alu_zero};
                    state_d  = S_WB;
                end
            end

            S_WAIT: begin
                res_d    = i_alu_result;
                cflags_d = {i_alu_overflow, i_alu_negative, i_alu_zero};
                state_d  = S_WB;
            end

            S_WB: begin
                // Commit happens on the edge leaving WB. During WB the debug
                // port still shows the old value of r[rd].
                if (func_q != FUNC_NOP) begin
                    rf_d[rd_q] = res_q;
                    flags_d    = cflags_q;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        en_d    = (state_d == S_EXEC) || (state_d == S_WAIT);
        done_d  = (state_d == S_WB);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // sample the values from before the edge, whatever order they are listed in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            s1_q     <= 8'h00;
            s2_q     <= 8'h00;
            func_q   <= 3'b000;
            rd_q     <= 2'd0;
            res_q    <= 8'h00;
            cflags_q <= 3'b000;
            flags_q  <= 3'b000;
            ready_q  <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            // NOTE: the four-entry register file is built from flops, not a
            // RAM macro, so it takes the asynchronous reset like any other state.
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            func_q   <= func_d;
            rd_q     <= rd_d;
            res_q    <= res_d;
            cflags_q <= cflags_d;
            flags_q  <= flags_d;
            ready_q  <= ready_d;
            en_q     <= en_d;
            done_q   <= done_d;
            rf_q     <= rf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_instr_ready = ready_q;
    assign o_alu_s1      = s1_q;
    assign o_alu_s2      = s2_q;
    assign o_alu_func    = func_q;
    assign o_alu_en      = en_q;
    assign o_done        = done_q;
    assign o_flags       = flags_q;
    assign o_dbg_data    = rf_q[i_dbg_addr];

    // -------------------------------------------------------------------------
    // Structural invariants between the registered outputs and the state
    // -------------------------------------------------------------------------
    a_ready_only_idle : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_instr_ready |-> (state_q == S_IDLE));

    a_done_only_wb : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_done == (state_q == S_WB));

    a_en_exec_wait : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_alu_en == ((state_q == S_EXEC) || (state_q == S_WAIT)));

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have parameter SLOW, default 1'b0, which when 1 inserts one extra ALU wait cycle per instruction.
REQ-002 The block SHALL have port i_clk, input, 1 bit, the single clock, with all state on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port i_instr_valid, input, 1 bit, qualifying i_instr.
REQ-005 The block SHALL have port o_instr_ready, output, 1 bit, asserted when an instruction can be accepted.
REQ-006 The block SHALL have port i_instr, input, 16 bits, with fields [15:13] func, [12:11] rd, [10:9] rs1, [8] imm_sel, and [7:0] imm8 (imm_sel=1) or rs2 in [1:0] (imm_sel=0).
REQ-007 The block SHALL have ports o_alu_s1 and o_alu_s2, output, 8 bits each, carrying the ALU operands.
REQ-008 The block SHALL have port o_alu_en, output, 1 bit, the ALU enable.
REQ-009 The block SHALL have port o_alu_func, output, 3 bits, the ALU function code.
REQ-010 The block SHALL have port i_alu_result, input, 8 bits, the ALU result.
REQ-011 The block SHALL have ports i_alu_zero, i_alu_negative and i_alu_overflow, input, 1 bit each, the ALU flags.
REQ-012 The block SHALL have port o_done, output, 1 bit, a one-cycle completion pulse.
REQ-013 The block SHALL have port o_flags, output, 3 bits, holding {overflow, negative, zero}.
REQ-014 The block SHALL have port i_dbg_addr, input, 2 bits, and port o_dbg_data, output, 8 bits, forming a combinational register-file read port.

Function
REQ-015 The block SHALL contain a register file of four 8-bit registers, r0-r3, all writable.
REQ-016 The state machine SHALL use states IDLE, EXEC, WAIT and WB.
- SLOW=0 path: IDLE->EXEC->WB->IDLE.
- SLOW=1 path: IDLE->EXEC->WAIT->WB->IDLE.
REQ-017 o_instr_ready SHALL be 1 only in IDLE.
- Acceptance occurs on the edge where i_instr_valid & o_instr_ready = 1.
- i_instr_valid in any other state SHALL be ignored.
REQ-018 On the acceptance edge the block SHALL latch:
- o_alu_s1 = r[rs1];
- o_alu_s2 = imm_sel ? imm8 : r[rs2];
- o_alu_func = func, and rd;
- and SHALL move to EXEC.
REQ-019 o_alu_en SHALL be 1 in EXEC and WAIT and 0 otherwise; o_alu_s1, o_alu_s2 and o_alu_func SHALL hold their last values outside EXEC/WAIT.
REQ-020 On the edge leaving EXEC (SLOW=0) or WAIT (SLOW=1), the block SHALL capture i_alu_result and the three flag inputs into internal holding registers.
REQ-021 In WB, o_done SHALL be 1 for exactly one cycle. On the edge leaving WB:
- r[rd] SHALL be written with the captured result;
- o_flags SHALL be updated with the captured flags.
REQ-022 func 3'b111 SHALL be a NOP: normal sequencing and o_done pulse, but no register write and o_flags unchanged.
REQ-023 Latency SHALL be acceptance edge to o_done high = 2 cycles (SLOW=0) or 3 cycles (SLOW=1); peak throughput SHALL be one instruction per 3 (SLOW=0) or 4 (SLOW=1) cycles.
REQ-024 An instruction whose rs1/rs2 equals the previous instruction's rd SHALL read the written-back value, with no forwarding needed, because acceptance only follows WB.
REQ-025 o_dbg_data SHALL equal r[i_dbg_addr] combinationally; a read of rd during WB SHALL return the old value, and the new value SHALL appear from the next cycle.
REQ-026 rs1 == rs2 == rd SHALL be legal and SHALL use pre-write operand values.

Reset
REQ-027 While i_rst_n = 0, independent of i_clk, the block SHALL force state = IDLE, r0-r3 = 8'h00, o_flags = 3'b000, o_alu_s1 = o_alu_s2 = 8'h00, o_alu_func = 3'b000, o_alu_en = 0, o_done = 0 and o_instr_ready = 0.
REQ-028 After i_rst_n releases, o_instr_ready SHALL be 1 in the next cycle.
REQ-029 Reset during EXEC, WAIT or WB SHALL abort the instruction with no register or flag write and no o_done pulse.

Verification
REQ-030 The bench SHALL cover: SLOW=0, instr ADD r1=r0+imm 8'h05 with a behavioural ALU (result = s1 + s2) -> o_alu_en high 1 cycle, o_done 2 cycles after acceptance, r1 = 8'h05.
REQ-031 The bench SHALL cover: back-to-back ADD r2=r1+r1 right after the previous case, valid held high -> ready low for 2 cycles, then r2 = 8'h0A.
REQ-032 The bench SHALL cover: ADD r3=r0+imm 8'h00 with the ALU asserting zero -> o_flags = 3'b001 and r3 = 8'h00; then NOP -> o_done pulses, o_flags remains 3'b001.
REQ-033 The bench SHALL cover: SLOW=1 ADD r1=r0+imm 8'h7F -> o_alu_en high 2 cycles, o_done 3 cycles after acceptance, r1 = 8'h7F.
REQ-034 The bench SHALL cover: i_rst_n pulsed low during EXEC after loading r1 = 8'h05 -> r1 = 8'h00, o_done never asserts, o_instr_ready = 1 the cycle after release.
